fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the core. Holds the fetch PC, issues one-at-a-time requests to the instruction cache, buffers returned words with their PCs in a small FIFO, and presents the head as the core's 64-bit `fetch_instr_pc` bundle. Honors the core's `stop` back-pressure and `j_accept`/`j_addr` redirects, and inserts NOP bubbles when no instruction is ready.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset.
- `FIFO_DEPTH`, 4, instruction buffer entries (power of two, ≥2).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `stop`  in  1  core stall; head is not consumed this cycle.
- `j_accept`  in  1  redirect strobe from core.
- `j_addr`  in  32  redirect target.
- `icache_req`  out  1  request valid.
- `icache_addr`  out  32  request address, word aligned.
- `icache_valid`  in  1  response valid for the outstanding request.
- `icache_data`  in  32  response instruction word.
- `fetch_instr_pc`  out  64  {pc[31:0], instr[31:0]} to core.
- `fetch_valid`  out  1  1 when `fetch_instr_pc` carries a real instruction, 0 for a bubble.

## Operation
- Registers: `fpc` (next request address), `opc` (PC of next instruction to deliver), FIFO of {pc, instr}, request FSM.
- FSM states: IDLE, WAIT, DROP.
  - IDLE -> WAIT: when `count + 0 < FIFO_DEPTH` (room for the response); drives `icache_req`=1, `icache_addr`=`fpc`.
  - WAIT: `icache_req` and `icache_addr` held stable until `icache_valid`. On `icache_valid`: push {`fpc`, `icache_data`}, `fpc`+=4, -> IDLE (or straight back to WAIT with new address if room remains).
  - WAIT + `j_accept` (no simultaneous `icache_valid`) -> DROP; `icache_req` deasserts.
  - DROP: next `icache_valid` discarded, -> IDLE. No new request while in DROP.
- Consume: when `stop`=0 and FIFO non-empty, head popped at clock edge; `opc` <= head pc + 4.
- Output: FIFO non-empty -> head entry, `fetch_valid`=1. Empty -> {`opc`, 32'h0000_0013} (ADDI x0,x0,0), `fetch_valid`=0.
- Redirect (`j_accept`=1): FIFO cleared, `fpc` and `opc` <= `j_addr`, pop suppressed. Priority: `j_accept` > `icache_valid` > `stop`. A response arriving in the same cycle as `j_accept` is discarded, FSM -> IDLE (not DROP).
- Full FIFO: no request issued; an outstanding request is always guaranteed space (request issued only when a slot is reserved).
- Push and pop in the same cycle: count unchanged, both take effect.
- `fpc` wraps modulo 2^32 with no special handling.
- Reset mid-request: FSM -> IDLE, outstanding response after reset is not expected (cache is reset by the same `rst`).

## Timing
- Reset values: `icache_req`=0, `icache_addr`=`RESET_PC`, `fetch_valid`=0, `fetch_instr_pc`={`RESET_PC`, 32'h0000_0013}; FIFO empty, `fpc`=`opc`=`RESET_PC`, FSM IDLE.
- First request: cycle after reset release.
- Response-to-output latency: 1 cycle (visible the cycle after `icache_valid`), 0 with bypass (see Configuration).
- Redirect-to-request: request for `j_addr` issued the cycle after `j_accept` (from IDLE), or one cycle after the dropped response (from DROP).
- Sustained throughput: one instruction per cycle only if the cache returns in 1 cycle and FIFO never fills; otherwise bounded by cache latency.

## Configuration
- `FETCH_BYPASS_EN` defined: when FIFO empty, `icache_valid`=1, `j_accept`=0, the response drives `fetch_instr_pc` combinationally that cycle with `fetch_valid`=1; if `stop`=0 it is consumed and not written to the FIFO.
- Undefined: every response goes through the FIFO; no combinational path from `icache_*` to `fetch_*`.

## Structure
- `fetch_pkg`: `NOP_INSTR` (32'h0000_0013), FSM state enum (IDLE/WAIT/DROP), `fetch_bundle_t` {pc, instr}.
- Sub-module `instr_fifo`: synchronous FIFO of `fetch_bundle_t`, push/pop/clear, `count`, full/empty; clear has priority over push.

## Test plan
- Reset, cache responds 1 cycle after each req with word = address: output sequence pc 0,4,8,… instr equal to pc, `fetch_valid`=1 from cycle 3 onward.
- `stop` held 10 cycles with DEPTH=4: exactly 4 entries buffered, `icache_req` stays 0, head remains pc 0x0; release -> 0x0,0x4,0x8,0xC delivered back to back.
- `j_accept` with `j_addr`=0x100 while request to 0x10 outstanding, response 3 cycles later: that response dropped, next output pc 0x100, no 0x10 ever delivered.
- `j_accept` coincident with `icache_valid`: response discarded, request for 0x100 issued next cycle.
- Cache latency 5 cycles: bubbles output {opc, 0x00000013}, `fetch_valid`=0 between instructions.
- `fpc`=0xFFFF_FFFC: next request address 0x0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: NOP encoding, request FSM states,
// and the {pc, instr} bundle carried from the cache to the core.
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} fsm_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_bundle_t;
endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO of fetch bundles with push/pop/clear; clear beats push.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clr_i,
    input  fetch_bundle_t            din_i,
    output fetch_bundle_t            head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    fetch_bundle_t      mem_q [DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        cnt_q;
    logic               push_ok, pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // A push into a full FIFO is only legal when a pop frees the slot the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding icache request, bundle FIFO, NOP bubbles.
// Define FETCH_BYPASS_EN to forward a response straight to the core when the FIFO is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic        j_accept,
    input  logic [31:0] j_addr,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_data,
    output logic [63:0] fetch_instr_pc,
    output logic        fetch_valid
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fsm_state_e     state_q, state_d;
    logic [31:0]    fpc_q, fpc_d, opc_q, opc_d;
    logic           push, pop, clr, full, empty, byp;
    logic [CW-1:0]  count, count_nxt;
    fetch_bundle_t  head, din;

    assign din         = '{pc: fpc_q, instr: icache_data};
    assign icache_addr = {fpc_q[31:2], 2'b00};

`ifdef FETCH_BYPASS_EN
    assign byp = (state_q == WAIT) && icache_valid && empty && !j_accept;
`else
    assign byp = 1'b0;
`endif

    assign count_nxt = count + CW'(push) - CW'(pop);

    always_comb begin
        state_d        = state_q;
        fpc_d          = fpc_q;
        opc_d          = opc_q;
        push           = 1'b0;
        pop            = 1'b0;
        clr            = 1'b0;
        fetch_valid    = !empty || byp;
        fetch_instr_pc = !empty ? head : (byp ? {fpc_q, icache_data} : {opc_q, NOP_INSTR});

        if (j_accept) begin
            clr   = 1'b1;
            fpc_d = {j_addr[31:2], 2'b00};
            opc_d = {j_addr[31:2], 2'b00};
            // A response landing with the redirect is simply discarded; otherwise wait it out.
            state_d = (state_q != IDLE && !icache_valid) ? DROP : IDLE;
        end else begin
            pop = !empty && !stop;
            if (fetch_valid && !stop) opc_d = fetch_instr_pc[63:32] + 32'd4;
            case (state_q)
                IDLE: if (!full) state_d = WAIT;
                WAIT: if (icache_valid) begin
                    push    = !(byp && !stop);
                    fpc_d   = fpc_q + 32'd4;
                    state_d = (count_nxt < CW'(FIFO_DEPTH)) ? WAIT : IDLE;
                end
                DROP: if (icache_valid) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // The IDLE->WAIT cycle already presents the request, so it is seen one edge earlier.
        icache_req = !rst && ((state_q == WAIT) || (state_q == IDLE && !full && !j_accept));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fpc_q   <= RESET_PC;
            opc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            opc_q   <= opc_d;
        end
    end

    instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clr_i   (clr),
        .din_i   (din),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cache BFM with variable latency plus a program-order
// reference (next expected pc, data = function of address) checked every cycle.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0, rst = 1'b1, stop = 1'b0, j_accept = 1'b0;
    logic [31:0] j_addr = '0;
    logic        icache_req, icache_valid;
    logic [31:0] icache_addr, icache_data;
    logic [63:0] fetch_instr_pc;
    logic        fetch_valid;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stop           (stop),
        .j_accept       (j_accept),
        .j_addr         (j_addr),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_valid   (icache_valid),
        .icache_data    (icache_data),
        .fetch_instr_pc (fetch_instr_pc),
        .fetch_valid    (fetch_valid)
    );

    function automatic logic [31:0] cword(input logic [31:0] a);
        return a ^ 32'h1357_0000;
    endfunction

    // Cache BFM: latches a request when free, answers `lat` cycles later for one cycle.
    int          lat = 1;
    int          c_cnt;
    logic        c_busy;
    logic [31:0] c_addr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c_busy <= 1'b0; c_cnt <= 0; c_addr <= '0;
            icache_valid <= 1'b0; icache_data <= '0;
        end else if (!c_busy && icache_req) begin
            c_busy <= 1'b1; c_addr <= icache_addr; c_cnt <= lat - 1;
            icache_data <= cword(icache_addr); icache_valid <= (lat == 1);
        end else if (c_busy && icache_valid) begin
            c_busy <= 1'b0; icache_valid <= 1'b0;
        end else if (c_busy) begin
            c_cnt <= c_cnt - 1; icache_valid <= (c_cnt == 1);
        end
    end

    int          total = 0, passed = 0, fails = 0, delivered = 0;
    logic [31:0] exp_pc = RPC;
    logic        s_req, s_fv, s_busy, s_valid, seen_req0;
    logic [31:0] s_addr, s_caddr;
    int          s_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: check outputs at negedge against the reference, then advance it.
    task automatic cyc();
        logic        fv, st, ja;
        logic [31:0] ja_addr;
        logic [63:0] b;
        @(negedge clk);
        fv = fetch_valid; b = fetch_instr_pc; st = stop; ja = j_accept; ja_addr = j_addr;
        s_req = icache_req; s_addr = icache_addr; s_fv = fv;
        s_busy = c_busy; s_cnt = c_cnt; s_caddr = c_addr; s_valid = icache_valid;
        if (!rst) begin
            chk("out_pc", {32'h0, b[63:32]}, {32'h0, exp_pc});
            chk("out_instr", {32'h0, b[31:0]}, {32'h0, fv ? cword(exp_pc) : NOP_INSTR});
            if (icache_req) begin
                chk("addr_align", {62'h0, icache_addr[1:0]}, 64'h0);
                if (icache_addr == 32'h0) seen_req0 = 1'b1;
            end
        end
        @(posedge clk);
        if (rst) exp_pc = RPC;
        else if (ja) exp_pc = ja_addr;
        else if (fv && !st) begin
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stop = 1'b0; j_accept = 1'b0; lat = 1;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic run_deliver(input int n, input int budget, input string tag);
        int target;
        int k;
        target = delivered + n;
        k = 0;
        while (delivered < target && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, {63'h0, delivered >= target}, 64'h1);
    endtask

    task automatic wait_cache(input int cnt, input logic [31:0] addr, input string tag);
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!(s_busy && s_cnt == cnt && !s_valid && (addr == 32'hFFFF_FFFF || s_caddr == addr)) && k < 300);
        chk(tag, {63'h0, k < 300}, 64'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        // Reset values
        @(negedge clk);
        chk("rst_req", {63'h0, icache_req}, 64'h0);
        chk("rst_addr", {32'h0, icache_addr}, {32'h0, RPC});
        chk("rst_valid", {63'h0, fetch_valid}, 64'h0);
        chk("rst_bundle", fetch_instr_pc, {RPC, NOP_INSTR});
        @(posedge clk); #1;
        do_reset();

        // Straight-line stream with 1-cycle cache
        cyc();
        chk("first_req", {63'h0, s_req}, 64'h1);
        chk("cyc1_bubble", {63'h0, s_fv}, 64'h0);
        cyc();
        chk("cyc2_bubble", {63'h0, s_fv}, 64'h0);
        cyc();
        chk("cyc3_valid", {63'h0, s_fv}, 64'h1);
        run_deliver(10, 100, "stream");

        // Stall until the FIFO fills, then drain back to back
        do_reset();
        stop = 1'b1;
        repeat (12) cyc();
        chk("full_no_req", {63'h0, s_req}, 64'h0);
        chk("full_head_valid", {63'h0, s_fv}, 64'h1);
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("drain_b2b", {63'h0, s_fv}, 64'h1);
        end
        run_deliver(4, 100, "after_drain");

        // Redirect while the request to 0x10 is outstanding
        do_reset();
        lat = 3;
        wait_cache(2, 32'h10, "wait_req10");
        j_accept = 1'b1; j_addr = 32'h100;
        cyc();
        j_accept = 1'b0;
        cyc();
        chk("drop_no_req", {63'h0, s_req}, 64'h0);
        run_deliver(6, 200, "redirect_deliver");

        // Redirect coincident with the response
        do_reset();
        lat = 3;
        wait_cache(1, 32'hFFFF_FFFF, "wait_coincident");
        j_accept = 1'b1; j_addr = 32'h100;
        cyc();
        j_accept = 1'b0;
        cyc();
        chk("coin_req", {63'h0, s_req}, 64'h1);
        chk("coin_addr", {32'h0, s_addr}, 64'h100);
        run_deliver(4, 100, "coin_deliver");

        // Slow cache produces bubbles between instructions
        lat = 5;
        nb = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (!s_fv) nb++;
        end
        chk("bubbles_seen", {63'h0, nb > 10}, 64'h1);

        // fpc wrap past 0xFFFF_FFFC
        lat = 1;
        seen_req0 = 1'b0;
        j_accept = 1'b1; j_addr = 32'hFFFF_FFF8;
        cyc();
        j_accept = 1'b0;
        run_deliver(4, 100, "wrap_deliver");
        chk("wrap_req0", {63'h0, seen_req0}, 64'h1);

        // Randomised stall / redirect / latency traffic
        for (int i = 0; i < 1500; i++) begin
            stop     = ($urandom_range(0, 9) < 3);
            j_accept = ($urandom_range(0, 29) == 0);
            j_addr   = $urandom & 32'hFFFF_FFFC;
            lat      = $urandom_range(1, 5);
            cyc();
        end
        stop = 1'b0; j_accept = 1'b0;
        run_deliver(8, 200, "rand_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
